// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, FSM state type and frame status payload.
package eth_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CRC_W     = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned CNT_W     = 17;
    localparam int unsigned FCS_BYTES = 4;

    localparam logic [BYTE_W-1:0] ETH_PREAMBLE  = 8'h55;
    localparam logic [BYTE_W-1:0] ETH_SFD       = 8'hD5;
    localparam logic [CRC_W-1:0]  CRC32_POLY    = 32'h04C11DB7;
    localparam logic [CRC_W-1:0]  CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0]  CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic             frame_ok;
        logic             crc_err;
        logic             len_err;
        logic [LEN_W-1:0] frame_len;
    } rx_status_t;

endpackage

// File: rtl/crc32_rx_d8.sv
// Byte-wide CRC-32 register; data bits enter LSB first into an MSB-first shift register,
// matching the transmit-side engine so a good frame leaves CRC32_RESIDUE behind.
module crc32_rx_d8
    import eth_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    logic [CRC_W-1:0] crc_next_c;

    // Eight serial CRC steps unrolled for one byte.
    always_comb begin
        crc_next_c = crc;
        for (int i = 0; i < BYTE_W; i++) begin
            if (crc_next_c[CRC_W-1] ^ data[i]) begin
                crc_next_c = {crc_next_c[CRC_W-2:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc_next_c = {crc_next_c[CRC_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC32_INIT;
        end else if (clr) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc_next_c;
        end
    end

endmodule

// File: rtl/gmii_rx_fcs_chk.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes without FCS through a
// 4-byte delay line, and reports CRC/length status one cycle after the last forwarded byte.
module gmii_rx_fcs_chk
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gmii_rx_dv,
    input  logic [BYTE_W-1:0] gmii_rxd,
    output logic              out_en,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_sof,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              crc_err,
    output logic              len_err,
    output logic [LEN_W-1:0]  frame_len
);

    rx_state_e                      state_q, state_d;
    logic                           dv_d;
    logic [FCS_BYTES-1:0][BYTE_W-1:0] dly_q;
    logic [2:0]                     dly_cnt_q;
    logic [CNT_W-1:0]               byte_cnt_q;
    logic                           sof_pend_q;
    logic [CRC_W-1:0]               crc_q;
    logic                           crc_en_c;
    logic                           crc_clr_c;
    logic                           frame_end_c;
    logic [CNT_W-1:0]               fwd_c;
    rx_status_t                     status_c;
    rx_status_t                     status_q;

    crc32_rx_d8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (crc_en_c),
        .clr   (crc_clr_c),
        .data  (gmii_rxd),
        .crc   (crc_q)
    );

    // Next-state and CRC control.
    always_comb begin
        state_d     = state_q;
        crc_en_c    = 1'b0;
        crc_clr_c   = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gmii_rx_dv && !dv_d) begin
                    state_d = (gmii_rxd == ETH_PREAMBLE) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (gmii_rxd == ETH_SFD) begin
                    state_d = ST_DATA;
                end else if (gmii_rxd != ETH_PREAMBLE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (gmii_rx_dv) begin
                    crc_en_c = 1'b1;
                end else begin
                    frame_end_c = 1'b1;
                    crc_clr_c   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // End-of-frame status derived from the byte count and CRC residue.
    always_comb begin
        fwd_c              = byte_cnt_q - CNT_W'(FCS_BYTES);
        status_c.crc_err   = (crc_q != CRC32_RESIDUE);
        status_c.len_err   = (byte_cnt_q < CNT_W'(MIN_LEN)) || (byte_cnt_q > CNT_W'(MAX_LEN));
        status_c.frame_ok  = !status_c.crc_err && !status_c.len_err;
        if (byte_cnt_q < CNT_W'(FCS_BYTES)) begin
            status_c.frame_len = '0;
        end else if (fwd_c[CNT_W-1]) begin
            status_c.frame_len = '1;
        end else begin
            status_c.frame_len = fwd_c[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dv_d       <= 1'b1;
            dly_q      <= '0;
            dly_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sof_pend_q <= 1'b0;
            out_en     <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            // Forcing dv_d high on frame end makes a no-IFG follow-on frame look like a held dv.
            dv_d       <= frame_end_c ? 1'b1 : gmii_rx_dv;
            out_en     <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            if (state_q == ST_PRE && state_d == ST_DATA) begin
                sof_pend_q <= 1'b1;
            end
            if (state_q == ST_DATA && gmii_rx_dv) begin
                dly_q <= {dly_q[FCS_BYTES-2:0], gmii_rxd};
                if (byte_cnt_q != '1) begin
                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                end
                if (dly_cnt_q == 3'(FCS_BYTES)) begin
                    out_en     <= 1'b1;
                    out_data   <= dly_q[FCS_BYTES-1];
                    out_sof    <= sof_pend_q;
                    sof_pend_q <= 1'b0;
                end else begin
                    dly_cnt_q <= dly_cnt_q + 3'd1;
                end
            end
            if (frame_end_c) begin
                frame_done <= 1'b1;
                status_q   <= status_c;
                dly_q      <= '0;
                dly_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sof_pend_q <= 1'b0;
            end
        end
    end

    assign frame_ok  = status_q.frame_ok;
    assign crc_err   = status_q.crc_err;
    assign len_err   = status_q.len_err;
    assign frame_len = status_q.frame_len;

endmodule
